// File: rtl/lag_pkg.sv
// Shared types and constants for the latency result writer and its statistics block.
// Header word layout lives here so the table map is defined in one place.
package lag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_SUMMARY,
        ST_DONE
    } lag_state_t;

    localparam logic [2:0] HDR_STATUS = 3'd0;
    localparam logic [2:0] HDR_MIN    = 3'd1;
    localparam logic [2:0] HDR_MAX    = 3'd2;
    localparam logic [2:0] HDR_SUM_LO = 3'd3;
    localparam logic [2:0] HDR_SUM_HI = 3'd4;
    localparam logic [2:0] HDR_TMO    = 3'd5;

    localparam logic [15:0] TIMEOUT_CODE_DEF = 16'hFFFF;

    function automatic logic [15:0] hdr_word(
        input logic [2:0]  idx,
        input logic [6:0]  cnt,
        input logic [15:0] min_v,
        input logic [15:0] max_v,
        input logic [23:0] sum_v,
        input logic [6:0]  tmo_v
    );
        case (idx)
            HDR_STATUS: hdr_word = {1'b1, 8'd0, cnt};
            HDR_MIN:    hdr_word = min_v;
            HDR_MAX:    hdr_word = max_v;
            HDR_SUM_LO: hdr_word = sum_v[15:0];
            HDR_SUM_HI: hdr_word = {8'd0, sum_v[23:16]};
            HDR_TMO:    hdr_word = {9'd0, tmo_v};
            default:    hdr_word = 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/lag_stats.sv
// Min/max/sum/timeout accumulators over a run of latency samples.
// Timed-out samples only bump the timeout count; clear has priority over update.
module lag_stats
    import lag_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        i_clear,
    input  logic        i_update,
    input  logic        i_timeout,
    input  logic [15:0] i_sample,
    output logic [15:0] o_min,
    output logic [15:0] o_max,
    output logic [23:0] o_sum,
    output logic [6:0]  o_tmo
);

    logic [15:0] r_min;
    logic [15:0] r_max;
    logic [23:0] r_sum;
    logic [6:0]  r_tmo;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_min <= 16'hFFFF;
            r_max <= 16'd0;
            r_sum <= 24'd0;
            r_tmo <= 7'd0;
        end else if (i_clear) begin
            r_min <= 16'hFFFF;
            r_max <= 16'd0;
            r_sum <= 24'd0;
            r_tmo <= 7'd0;
        end else if (i_update) begin
            if (i_timeout) begin
                r_tmo <= r_tmo + 7'd1;
            end else begin
                if (i_sample < r_min) r_min <= i_sample;
                if (i_sample > r_max) r_max <= i_sample;
                // 122 full-scale samples fit in 23 bits, so no saturation.
                r_sum <= r_sum + {8'd0, i_sample};
            end
        end
    end

    assign o_min = r_min;
    assign o_max = r_max;
    assign o_sum = r_sum;
    assign o_tmo = r_tmo;

endmodule

// File: rtl/lag_result_writer.sv
// Streams raw latency samples into the HPS result table, then writes the statistics header
// and raises valid once the table is stable. All table-port outputs are registered.
module lag_result_writer
    import lag_pkg::*;
#(
    parameter int          NUM_SAMPLES  = 32,
    parameter int          SAMPLE_BASE  = 6,
    parameter logic [15:0] TIMEOUT_CODE = TIMEOUT_CODE_DEF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic        sample_valid,
    input  logic        sample_timeout,
    input  logic [15:0] sample_us,
    output logic        busy,
    output logic [6:0]  sample_cnt,
    output logic        valid,
    output logic [1:0]  wr,
    output logic [15:0] din,
    output logic [6:0]  addr
);

    localparam logic [6:0] LP_NUM  = 7'(NUM_SAMPLES);
    localparam logic [6:0] LP_BASE = 7'(SAMPLE_BASE);

    lag_state_t  r_state;
    lag_state_t  w_state_nxt;
    logic [6:0]  r_sample_cnt;
    logic [6:0]  w_sample_cnt_nxt;
    logic [2:0]  r_hdr_idx;
    logic [2:0]  w_hdr_idx_nxt;
    logic [2:0]  w_hdr_inc;
    logic [1:0]  r_wr;
    logic [1:0]  w_wr_nxt;
    logic [15:0] r_din;
    logic [15:0] w_din_nxt;
    logic [6:0]  r_addr;
    logic [6:0]  w_addr_nxt;
    logic        r_valid;
    logic        w_valid_nxt;

    logic        w_accept;
    logic        w_run_full;
    logic [15:0] w_min;
    logic [15:0] w_max;
    logic [23:0] w_sum;
    logic [6:0]  w_tmo;

    // start wins over a coincident sample; the count guard blocks extra samples.
    assign w_accept   = (r_state == ST_COLLECT) && sample_valid && !start && (r_sample_cnt < LP_NUM);
    assign w_run_full = (r_state == ST_COLLECT) && (r_sample_cnt == LP_NUM);
    assign w_hdr_inc  = r_hdr_idx + 3'd1;

    lag_stats u_stats (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .i_clear   (start),
        .i_update  (w_accept),
        .i_timeout (sample_timeout),
        .i_sample  (sample_us),
        .o_min     (w_min),
        .o_max     (w_max),
        .o_sum     (w_sum),
        .o_tmo     (w_tmo)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_sample_cnt <= 7'd0;
            r_hdr_idx    <= 3'd0;
            r_wr         <= 2'b00;
            r_din        <= 16'd0;
            r_addr       <= 7'd0;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sample_cnt <= w_sample_cnt_nxt;
            r_hdr_idx    <= w_hdr_idx_nxt;
            r_wr         <= w_wr_nxt;
            r_din        <= w_din_nxt;
            r_addr       <= w_addr_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_sample_cnt_nxt = r_sample_cnt;
        w_hdr_idx_nxt    = r_hdr_idx;
        w_wr_nxt         = 2'b00;
        w_din_nxt        = r_din;
        w_addr_nxt       = r_addr;
        w_valid_nxt      = r_valid;

        if (start) begin
            w_state_nxt      = ST_COLLECT;
            w_sample_cnt_nxt = 7'd0;
            w_hdr_idx_nxt    = 3'd0;
            w_valid_nxt      = 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_accept) begin
                        w_wr_nxt         = 2'b11;
                        w_addr_nxt       = LP_BASE + r_sample_cnt;
                        w_din_nxt        = sample_timeout ? TIMEOUT_CODE : sample_us;
                        w_sample_cnt_nxt = r_sample_cnt + 7'd1;
                    end else if (w_run_full) begin
                        // Stats settled on the last sample's write cycle; header word 0 goes out next.
                        w_state_nxt   = ST_SUMMARY;
                        w_hdr_idx_nxt = HDR_STATUS;
                        w_wr_nxt      = 2'b11;
                        w_addr_nxt    = {4'd0, HDR_STATUS};
                        w_din_nxt     = hdr_word(HDR_STATUS, r_sample_cnt, w_min, w_max, w_sum, w_tmo);
                    end
                end
                ST_SUMMARY: begin
                    if (r_hdr_idx == HDR_TMO) begin
                        w_state_nxt = ST_DONE;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_hdr_idx_nxt = w_hdr_inc;
                        w_wr_nxt      = 2'b11;
                        w_addr_nxt    = {4'd0, w_hdr_inc};
                        w_din_nxt     = hdr_word(w_hdr_inc, r_sample_cnt, w_min, w_max, w_sum, w_tmo);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state == ST_COLLECT) || (r_state == ST_SUMMARY);
    assign sample_cnt = r_sample_cnt;
    assign valid      = r_valid;
    assign wr         = r_wr;
    assign din        = r_din;
    assign addr       = r_addr;

endmodule

// File: tb/tb_lag_result_writer.sv
// Directed bench for lag_result_writer: a 4-sample instance and a 122-sample instance
// share clock, reset and sample inputs; each has its own start.
module tb_lag_result_writer;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        sample_valid = 1'b0;
    logic        sample_timeout = 1'b0;
    logic [15:0] sample_us = 16'd0;

    logic        a_busy, b_busy, a_valid, b_valid;
    logic [6:0]  a_cnt, b_cnt, a_addr, b_addr;
    logic [1:0]  a_wr, b_wr;
    logic [15:0] a_din, b_din;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wcnt_a = 0;
    int wcnt_b = 0;
    int bad_wr = 0;
    int hdr5_cyc_a = -1;
    int vrise_cyc_a = -1;
    logic a_valid_q = 1'b0;
    logic [15:0] mem_a [128];
    logic [15:0] mem_b [128];

    lag_result_writer #(.NUM_SAMPLES(4)) dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start_a), .sample_valid(sample_valid),
        .sample_timeout(sample_timeout), .sample_us(sample_us), .busy(a_busy), .sample_cnt(a_cnt),
        .valid(a_valid), .wr(a_wr), .din(a_din), .addr(a_addr)
    );

    lag_result_writer #(.NUM_SAMPLES(122)) dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start_b), .sample_valid(sample_valid),
        .sample_timeout(sample_timeout), .sample_us(sample_us), .busy(b_busy), .sample_cnt(b_cnt),
        .valid(b_valid), .wr(b_wr), .din(b_din), .addr(b_addr)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc++;

    // Table model: records every write seen by each instance.
    always @(negedge clk_sys) begin
        if (a_wr == 2'b11) begin
            mem_a[a_addr] = a_din;
            wcnt_a++;
            if (a_addr == 7'd5) hdr5_cyc_a = cyc;
        end
        if (b_wr == 2'b11) begin
            mem_b[b_addr] = b_din;
            wcnt_b++;
        end
        if ((a_wr != 2'b00 && a_wr != 2'b11) || (b_wr != 2'b00 && b_wr != 2'b11)) bad_wr++;
        if (a_valid && !a_valid_q) vrise_cyc_a = cyc;
        a_valid_q = a_valid;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic [15:0] us, input logic tmo);
        sample_valid = 1'b1;
        sample_us = us;
        sample_timeout = tmo;
        tick();
        sample_valid = 1'b0;
        sample_timeout = 1'b0;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic clear_mem_a();
        for (int i = 0; i < 128; i++) mem_a[i] = 16'hDEAD;
    endtask

    task automatic wait_valid(input logic which_b, input string name);
        int n = 0;
        while (!(which_b ? b_valid : a_valid) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if ((which_b ? b_valid : a_valid) !== 1'b1) begin
            failures++;
            $display("FAIL %s: valid never rose within 300 cycles, got valid=0 required 1", name);
        end
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        checks++;
        if ({a_valid, a_busy, a_wr, a_din, a_addr, a_cnt} !== 34'd0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b busy=%b wr=%b din=%h addr=%0d cnt=%0d required all 0",
                     a_valid, a_busy, a_wr, a_din, a_addr, a_cnt);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        // A sample while idle must be ignored by both instances.
        send(16'd77, 1'b0);
        checks++;
        if (a_wr !== 2'b00 || a_cnt !== 7'd0 || b_wr !== 2'b00 || b_cnt !== 7'd0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_sample: got a_wr=%b a_cnt=%0d b_wr=%b b_cnt=%0d busy=%b required 00/0/00/0/0",
                     a_wr, a_cnt, b_wr, b_cnt, a_busy);
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp_hdr [6];
        clear_mem_a();
        wcnt_a = 0;
        pulse_start_a();
        checks++;
        if (a_busy !== 1'b1 || a_valid !== 1'b0 || a_cnt !== 7'd0) begin
            failures++;
            $display("FAIL start_state: got busy=%b valid=%b cnt=%0d required 1/0/0", a_busy, a_valid, a_cnt);
        end
        send(16'd100, 1'b0);
        checks++;
        if (a_wr !== 2'b11 || a_addr !== 7'd6 || a_din !== 16'h0064 || a_cnt !== 7'd1) begin
            failures++;
            $display("FAIL sample_latency: got wr=%b addr=%0d din=%h cnt=%0d required 11/6/0064/1",
                     a_wr, a_addr, a_din, a_cnt);
        end
        send(16'd250, 1'b0);
        send(16'd50, 1'b0);
        send(16'd300, 1'b0);
        wait_valid(1'b0, "basic_valid");
        checks++;
        if (mem_a[6] !== 16'h0064 || mem_a[7] !== 16'h00FA || mem_a[8] !== 16'h0032 || mem_a[9] !== 16'h012C) begin
            failures++;
            $display("FAIL basic_samples: got %h %h %h %h required 0064 00FA 0032 012C",
                     mem_a[6], mem_a[7], mem_a[8], mem_a[9]);
        end
        exp_hdr = '{16'h8004, 16'h0032, 16'h012C, 16'h02BC, 16'h0000, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mem_a[i] !== exp_hdr[i]) begin
                failures++;
                $display("FAIL basic_hdr%0d: got %h required %h", i, mem_a[i], exp_hdr[i]);
            end
        end
        checks++;
        if (vrise_cyc_a !== hdr5_cyc_a + 1 || wcnt_a !== 10) begin
            failures++;
            $display("FAIL basic_valid_timing: got valid cycle=%0d hdr5 cycle=%0d writes=%0d required hdr5+1 and 10 writes",
                     vrise_cyc_a, hdr5_cyc_a, wcnt_a);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] exp_mem [10];
        clear_mem_a();
        pulse_start_a();
        send(16'd100, 1'b0);
        send(16'h1234, 1'b1);
        send(16'd200, 1'b0);
        send(16'h0007, 1'b1);
        wait_valid(1'b0, "tmo_valid");
        exp_mem = '{16'h8004, 16'h0064, 16'h00C8, 16'h012C, 16'h0000, 16'h0002,
                    16'h0064, 16'hFFFF, 16'h00C8, 16'hFFFF};
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (mem_a[i] !== exp_mem[i]) begin
                failures++;
                $display("FAIL tmo_addr%0d: got %h required %h", i, mem_a[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_full_run();
        int wa;
        wcnt_b = 0;
        wa = wcnt_a;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        // dut_a sits in DONE and must ignore all of these.
        for (int i = 0; i < 122; i++) send(16'hFFFF, 1'b0);
        wait_valid(1'b1, "full_valid");
        checks++;
        if (mem_b[127] !== 16'hFFFF || mem_b[6] !== 16'hFFFF || wcnt_b !== 128) begin
            failures++;
            $display("FAIL full_samples: got m127=%h m6=%h writes=%0d required FFFF FFFF 128",
                     mem_b[127], mem_b[6], wcnt_b);
        end
        checks++;
        if (mem_b[0] !== 16'h807A || mem_b[1] !== 16'hFFFF || mem_b[2] !== 16'hFFFF) begin
            failures++;
            $display("FAIL full_hdr_a: got %h %h %h required 807A FFFF FFFF", mem_b[0], mem_b[1], mem_b[2]);
        end
        checks++;
        if (mem_b[3] !== 16'hFF86 || mem_b[4] !== 16'h0079 || mem_b[5] !== 16'h0000) begin
            failures++;
            $display("FAIL full_hdr_sum: got %h %h %h required FF86 0079 0000", mem_b[3], mem_b[4], mem_b[5]);
        end
        checks++;
        if (wcnt_a !== wa || a_cnt !== 7'd4 || a_valid !== 1'b1) begin
            failures++;
            $display("FAIL done_ignore: got writes=%0d cnt=%0d valid=%b required %0d/4/1", wcnt_a, a_cnt, a_valid, wa);
        end
    endtask

    task automatic test_start_in_summary();
        int n;
        int wsnap;
        clear_mem_a();
        pulse_start_a();
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        send(16'd30, 1'b0);
        send(16'd40, 1'b0);
        n = 0;
        while (!(a_wr == 2'b11 && a_addr == 7'd2) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (a_wr !== 2'b11 || a_addr !== 7'd2) begin
            failures++;
            $display("FAIL abort_reach_hdr2: got wr=%b addr=%0d required 11/2", a_wr, a_addr);
        end
        pulse_start_a();
        wsnap = wcnt_a;
        checks++;
        if (a_wr !== 2'b00 || a_valid !== 1'b0 || a_cnt !== 7'd0 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_state: got wr=%b valid=%b cnt=%0d busy=%b required 00/0/0/1", a_wr, a_valid, a_cnt, a_busy);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (wcnt_a !== wsnap || a_valid !== 1'b0 || mem_a[3] !== 16'hDEAD || mem_a[5] !== 16'hDEAD) begin
            failures++;
            $display("FAIL abort_no_hdr: got writes=%0d valid=%b m3=%h m5=%h required %0d/0/DEAD/DEAD",
                     wcnt_a, a_valid, mem_a[3], mem_a[5], wsnap);
        end
        send(16'd7, 1'b0);
        send(16'd8, 1'b0);
        send(16'd9, 1'b0);
        send(16'd10, 1'b0);
        wait_valid(1'b0, "abort_rerun_valid");
        checks++;
        if (mem_a[0] !== 16'h8004 || mem_a[1] !== 16'h0007 || mem_a[2] !== 16'h000A || mem_a[3] !== 16'h0022 || mem_a[6] !== 16'h0007) begin
            failures++;
            $display("FAIL abort_rerun: got %h %h %h %h %h required 8004 0007 000A 0022 0007",
                     mem_a[0], mem_a[1], mem_a[2], mem_a[3], mem_a[6]);
        end
    endtask

    task automatic test_back_to_back();
        int wsnap;
        wsnap = wcnt_a;
        start_a = 1'b1;
        sample_valid = 1'b1;
        sample_us = 16'd55;
        tick();
        start_a = 1'b0;
        sample_valid = 1'b0;
        checks++;
        if (a_wr !== 2'b00 || a_cnt !== 7'd0 || a_busy !== 1'b1 || a_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_and_sample: got wr=%b cnt=%0d busy=%b valid=%b required 00/0/1/0", a_wr, a_cnt, a_busy, a_valid);
        end
        tick();
        checks++;
        if (wcnt_a !== wsnap) begin
            failures++;
            $display("FAIL start_and_sample_write: got writes=%0d required %0d", wcnt_a, wsnap);
        end
    endtask

    task automatic test_async_reset();
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_wr !== 2'b00 || a_cnt !== 7'd0) begin
            failures++;
            $display("FAIL async_reset: got valid=%b busy=%b wr=%b cnt=%0d required 0/0/00/0", a_valid, a_busy, a_wr, a_cnt);
        end
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: got busy=%b valid=%b required 0/0", a_busy, a_valid);
        end
        clear_mem_a();
        pulse_start_a();
        send(16'd3, 1'b0);
        send(16'd1, 1'b0);
        send(16'd4, 1'b1);
        send(16'd5, 1'b0);
        wait_valid(1'b0, "post_reset_valid");
        checks++;
        if (mem_a[0] !== 16'h8004 || mem_a[1] !== 16'h0001 || mem_a[2] !== 16'h0005 || mem_a[3] !== 16'h0009 || mem_a[5] !== 16'h0001) begin
            failures++;
            $display("FAIL post_reset_run: got %h %h %h %h %h required 8004 0001 0005 0009 0001",
                     mem_a[0], mem_a[1], mem_a[2], mem_a[3], mem_a[5]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_full_run();
        test_start_in_summary();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (bad_wr !== 0) begin
            failures++;
            $display("FAIL wr_encoding: got %0d cycles with wr not 00/11 required 0", bad_wr);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lag_result_writer.md
Name: lag_result_writer

Overview:
- Upstream producer for the HPS extension result table (128 x 16-bit words, addr/din/wr write port plus a `valid` flag).
- Collects a run of latency samples from the measurement engine and writes each raw sample into the table.
- At the end of the run, computes min/max/sum/timeout statistics, writes them into the table header, then raises `valid` so the HPS side bumps its version and serves the data.

Parameters:
- NUM_SAMPLES, 32, samples per run; legal range 1..122.
- SAMPLE_BASE, 6, table address of sample 0; samples occupy SAMPLE_BASE..SAMPLE_BASE+NUM_SAMPLES-1.
- TIMEOUT_CODE, 16'hFFFF, value stored for a timed-out sample.

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new run (legal in any state).
- sample_valid  in  1  one-cycle pulse; sample_us is a completed measurement.
- sample_timeout  in  1  qualifies sample_valid; the measurement timed out.
- sample_us  in  16  measured latency in microseconds.
- busy  out  1  run in progress (COLLECT or SUMMARY).
- sample_cnt  out  7  samples accepted in the current run.
- valid  out  1  table contents complete and consistent.
- wr  out  2  byte write enables to the table; always 2'b00 or 2'b11.
- din  out  16  table write data.
- addr  out  7  table write address.

Behaviour:
- Reset values: state=IDLE, valid=0, busy=0, wr=0, din=0, addr=0, sample_cnt=0, min=16'hFFFF, max=0, sum=0, tmo=0.
- States:
  - IDLE: wait for start.
  - COLLECT: accept samples.
  - SUMMARY: write 6 header words, one per cycle.
  - DONE: hold valid=1 until the next start.
- Start handling: start in any state (including mid-SUMMARY) → next cycle: valid=0, busy=1, counters and statistics cleared, state=COLLECT. Any table write already presented that cycle is cancelled (wr=0).
- Sample write in COLLECT: on sample_valid, the next cycle drives wr=2'b11, addr=SAMPLE_BASE+sample_cnt, din=(sample_timeout ? TIMEOUT_CODE : sample_us), and sample_cnt increments. Latency is 1 cycle, registered outputs.
- Timed-out samples increment tmo only; they are excluded from min/max/sum.
- Statistics update: min/max compare unsigned. sum is 24-bit and cannot overflow (122*65535 < 2^23); no saturation is needed.
- Run completion: when sample_cnt reaches NUM_SAMPLES (after the last sample's write cycle), the next cycle enters SUMMARY. Further sample_valid pulses in SUMMARY or DONE are ignored.
- SUMMARY writes (wr=2'b11), in order on consecutive cycles:
  - addr0 = {1'b1, 8'd0, sample_cnt}
  - addr1 = min
  - addr2 = max
  - addr3 = sum[15:0]
  - addr4 = {8'd0, sum[23:16]}
  - addr5 = {9'd0, tmo}
- Entering DONE: wr=0 and valid=1 on the cycle after the addr5 write. The table is stable before valid rises, so the HPS version increments exactly once per run.
- All-timeout run: min stays 16'hFFFF, max=0, sum=0 (no special-casing).
- start and sample_valid in the same cycle: start wins and the sample is dropped.
- sample_valid in IDLE: ignored.
- Async reset mid-run: all outputs return to reset values immediately. Table contents are left stale, but valid=0 flags them.
- wr is never asserted outside COLLECT sample cycles and SUMMARY.

Decomposition:
- Shared package lag_pkg:
  - header address constants (HDR_STATUS=0, HDR_MIN=1, HDR_MAX=2, HDR_SUM_LO=3, HDR_SUM_HI=4, HDR_TMO=5)
  - state enum typedef
  - TIMEOUT_CODE default
- One sub-module: lag_stats, which holds min/max/sum/tmo accumulators with clear and update inputs, and is reused later for on-screen stats. The FSM and table write mux stay in lag_result_writer.

Test Plan:
- Reset, then NUM_SAMPLES=4, start, samples 100, 250, 50, 300 → writes addr6..9 = 0x0064, 0x00FA, 0x0032, 0x012C. Header: addr0=0x8004, addr1=0x0032, addr2=0x012C, addr3=0x02BC, addr4=0x0000, addr5=0x0000. valid rises 1 cycle after the addr5 write.
- NUM_SAMPLES=4, samples 100, timeout, 200, timeout → addr7 and addr9 = 0xFFFF. min=0x0064, max=0x00C8, sum=0x012C, tmo=0x0002.
- NUM_SAMPLES=122, all samples 0xFFFF (non-timeout) → last sample written at addr127. sum=0x79FF86 (addr3=0xFF86, addr4=0x0079); no address wrap beyond 127.
- Assert start during the SUMMARY cycle writing addr2 → no further header writes, valid stays 0, sample_cnt=0, and a new run completes normally.
- start and sample_valid in the same cycle, and sample_valid while in IDLE/DONE → the sample is not written and sample_cnt is unchanged.
- Drop reset_n low mid-COLLECT → valid/busy/wr go to 0 immediately (asynchronously); after release, the state is IDLE and the next start works.
